// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame controller.
// State encoding and byte width used by the controller and deserializer.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/spi_byte_deser.sv
// LSB-first serial-to-byte shifter with bit counter.
// byte_o/byte_done_o show the byte completed by the current edge's bit.
module spi_byte_deser
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic              byte_done_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic [2:0]        bit_cnt_o
);

  logic [BYTE_W-1:0] sh_q;
  logic [BYTE_W-1:0] sh_d;
  logic [2:0]        cnt_q;
  logic [2:0]        cnt_d;

  // Shift new bits in from the top so the first bit ends in bit 0.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (en_i) begin
      sh_d  = {bit_i, sh_q[BYTE_W-1:1]};
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Shifter and counter registers.
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    cnt_q <= cnt_d;
  end

  assign byte_o      = {bit_i, sh_q[BYTE_W-1:1]};
  assign byte_done_o = en_i && (cnt_q == 3'd7);
  assign bit_cnt_o   = cnt_q;

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer: gathers FRAME_BYTES bytes behind cs_n,
// aborts partial frames, and hands frames off via valid/ready.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_BYTES = 4,
  parameter int TIMEOUT     = 16,
  localparam int BCW = $clog2(FRAME_BYTES + 1),
  localparam int FW  = BYTE_W * FRAME_BYTES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bit_in,
  input  logic           bit_valid,
  input  logic           cs_n,
  output logic [FW-1:0]  frame_data,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [BCW-1:0] byte_count,
  output logic           busy,
  output logic           err_abort
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_B = BCW'(FRAME_BYTES - 1);
  localparam logic [TCW-1:0] TO_MAX = TCW'(TIMEOUT);

  state_e state_q;
  state_e state_d;

  logic [FW-1:0]  buf_q;
  logic [FW-1:0]  buf_d;
  logic [FW-1:0]  frame_q;
  logic [FW-1:0]  frame_d;
  logic           fv_q;
  logic           fv_d;
  logic [BCW-1:0] bc_q;
  logic [BCW-1:0] bc_d;
  logic [TCW-1:0] to_q;
  logic [TCW-1:0] to_d;
  logic           busy_q;
  logic           err_q;

  logic              abort;
  logic              done;
  logic              partial;
  logic              des_en;
  logic              des_clr;
  logic              byte_done;
  logic [BYTE_W-1:0] byte_w;
  logic [2:0]        bit_cnt;

  spi_byte_deser u_deser (
    .clk         (clk),
    .clr_i       (des_clr),
    .en_i        (des_en),
    .bit_i       (bit_in),
    .byte_done_o (byte_done),
    .byte_o      (byte_w),
    .bit_cnt_o   (bit_cnt)
  );

  // Next state: completion beats abort; any exit from RECV flushes.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    frame_d = frame_q;
    fv_d    = fv_q;
    bc_d    = bc_q;
    to_d    = '0;
    abort   = 1'b0;
    done    = 1'b0;
    partial = (bit_cnt != 3'd0) || (bc_q != '0);
    des_en  = (state_q == ST_RECV) && bit_valid;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (!cs_n) state_d = ST_RECV;
      end
      (state_q == ST_RECV): begin
        if (bit_valid) begin
          if (byte_done) begin
            buf_d[int'(bc_q)*BYTE_W +: BYTE_W] = byte_w;
            bc_d = bc_q + BCW'(1);
            if (bc_q == LAST_B) begin
              done    = 1'b1;
              frame_d = buf_d;
              fv_d    = 1'b1;
              bc_d    = '0;
              buf_d   = '0;
              state_d = ST_HOLD;
            end
          end
        end else begin
          to_d = (to_q == TO_MAX) ? to_q : to_q + TCW'(1);
        end
        if (!done) begin
          if (cs_n) begin
            abort   = partial;
            state_d = ST_IDLE;
          end else if (!bit_valid && to_d == TO_MAX && partial) begin
            abort   = 1'b1;
            state_d = ST_IDLE;
          end
          if (state_d == ST_IDLE) begin
            bc_d  = '0;
            buf_d = '0;
            to_d  = '0;
          end
        end
      end
      (state_q == ST_HOLD): begin
        if (frame_ready) begin
          fv_d    = 1'b0;
          state_d = cs_n ? ST_IDLE : ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    des_clr = !rst_n ||
              (state_q == ST_RECV && state_d != ST_RECV);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      bc_q    <= '0;
      to_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      bc_q    <= bc_d;
      to_q    <= to_d;
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= abort;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = fv_q;
  assign byte_count  = bc_q;
  assign busy        = busy_q;
  assign err_abort   = err_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: directed cases plus random traffic
// checked every cycle against a bit-queue reference model.
module tb_spi_frame_ctrl;

  localparam int FB  = 2;
  localparam int TO  = 16;
  localparam int FW  = 8 * FB;
  localparam int BCW = $clog2(FB + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           bit_in = 1'b0;
  logic           bit_valid = 1'b0;
  logic           cs_n = 1'b1;
  logic           frame_ready = 1'b0;
  logic [FW-1:0]  frame_data;
  logic           frame_valid;
  logic [BCW-1:0] byte_count;
  logic           busy;
  logic           err_abort;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  spi_frame_ctrl #(.FRAME_BYTES(FB), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .cs_n        (cs_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .byte_count  (byte_count),
    .busy        (busy),
    .err_abort   (err_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 receiving, 2 holding.
  logic [FW-1:0] m_frame = '0;
  bit            m_fv = 1'b0;
  bit            m_err = 1'b0;
  int            m_mode = 0;
  int            m_idle = 0;
  bit            m_q[$];

  always @(posedge clk) begin
    bit part;
    bit done;
    m_err = 1'b0;
    done  = 1'b0;
    if (!rst_n) begin
      m_mode  = 0;
      m_q.delete();
      m_frame = '0;
      m_fv    = 1'b0;
      m_idle  = 0;
    end else if (m_mode == 0) begin
      if (!cs_n) m_mode = 1;
    end else if (m_mode == 1) begin
      part = (m_q.size() != 0);
      if (bit_valid) begin
        m_idle = 0;
        m_q.push_back(bit_in);
        if (m_q.size() == FW) begin
          for (int i = 0; i < FW; i++) m_frame[i] = m_q[i];
          m_q.delete();
          m_fv   = 1'b1;
          m_mode = 2;
          done   = 1'b1;
        end
      end else if (m_idle < TO) begin
        m_idle++;
      end
      if (!done && part &&
          (cs_n || (!bit_valid && m_idle >= TO)))
        m_err = 1'b1;
      if (!done && (cs_n || m_err)) begin
        m_mode = 0;
        m_q.delete();
      end
    end else begin
      if (frame_ready) begin
        m_fv   = 1'b0;
        m_mode = cs_n ? 0 : 1;
      end
    end
    if (m_mode != 1) m_idle = 0;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data", 32'(frame_data), 32'(m_frame));
      chk("m_valid", 32'(frame_valid), 32'(m_fv));
      chk("m_bcnt", 32'(byte_count), 32'(m_q.size() / 8));
      chk("m_busy", 32'(busy), 32'(m_mode != 0));
      chk("m_err", 32'(err_abort), 32'(m_err));
    end
  end

  task automatic step(input bit cs, input bit bv,
                      input bit b, input bit rdy);
    cs_n        = cs;
    bit_valid   = bv;
    bit_in      = b;
    frame_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input bit cs_last,
                           input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      step((i == 7) ? cs_last : 1'b0, 1'b1, v[i], 1'b0);
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_data", 32'(frame_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // First frame: 0x53 then 0xFC.
    step(0, 0, 0, 0);
    b0 = 8'b0101_0011;
    b1 = 8'b1111_1100;
    send_byte(0, b0);
    chk("bcnt_1", 32'(byte_count), 1);
    send_byte(0, b1);
    chk("fv_1", 32'(frame_valid), 1);
    chk("fd_fc53", 32'(frame_data), 32'h0000_FC53);
    chk("model_fc53", 32'(m_frame), 32'h0000_FC53);
    chk("bcnt_0", 32'(byte_count), 0);

    // Back-pressure: bits arriving in HOLD are dropped.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, i[0], 0);
      chk("bp_data", 32'(frame_data), 32'h0000_FC53);
      chk("bp_bcnt", 32'(byte_count), 0);
    end
    step(0, 0, 0, 1);
    chk("rdy_fv", 32'(frame_valid), 0);
    chk("rdy_busy", 32'(busy), 1);

    // Abort after 5 bits.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    chk("abort_pulse", 32'(err_abort), 1);
    step(1, 0, 0, 0);
    chk("abort_end", 32'(err_abort), 0);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_keep", 32'(frame_data), 32'h0000_FC53);

    step(0, 0, 0, 0);
    send_byte(0, 8'hA5);
    send_byte(0, 8'h01);
    chk("fd_01a5", 32'(frame_data), 32'h0000_01A5);
    step(1, 0, 0, 1);
    chk("rel_busy", 32'(busy), 0);

    // Timeout: 3 bits then 16 idle cycles.
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0);
      chk("to_early", 32'(err_abort), 0);
    end
    step(0, 0, 0, 0);
    chk("to_pulse", 32'(err_abort), 1);
    chk("to_idle", 32'(busy), 0);
    step(0, 0, 0, 0);
    chk("to_end", 32'(err_abort), 0);

    // Empty RECV never times out.
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      chk("empty_noerr", 32'(err_abort), 0);
    end
    chk("empty_busy", 32'(busy), 1);

    // Last bit together with cs_n rising.
    send_byte(0, 8'h3C);
    send_byte(1, 8'h81);
    chk("corner_fv", 32'(frame_valid), 1);
    chk("corner_err", 32'(err_abort), 0);
    chk("corner_fd", 32'(frame_data), 32'h0000_813C);
    step(1, 0, 0, 1);
    chk("corner_rel", 32'(frame_valid), 0);

    // Reset while holding a frame.
    step(0, 0, 0, 0);
    send_byte(0, 8'h34);
    send_byte(0, 8'h12);
    chk("pre_rst_fv", 32'(frame_valid), 1);
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    chk("hrst_fv", 32'(frame_valid), 0);
    chk("hrst_fd", 32'(frame_data), 0);
    chk("hrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    send_byte(0, 8'h77);
    send_byte(0, 8'h66);
    chk("clean_fd", 32'(frame_data), 32'h0000_6677);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 70,
           1'($urandom),
           $urandom_range(0, 99) < 40);
    end
    rst_n = 1'b1;
    step(1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Frame-level controller that sequences a serial LSB-first byte deserializer into fixed-length multi-byte frames. It gates reception with an active-low chip-select and flushes partial data on abort or inactivity timeout. Each completed frame is presented to the downstream consumer through a valid/ready handshake. It sits between the serial pin interface and the byte-oriented command/register logic.

Parameters:
FRAME_BYTES, 4, number of bytes per frame (2..16)
TIMEOUT, 16, consecutive RECV cycles without bit_valid that abort a partial frame (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
bit_in  input  1  serial data bit, sampled when bit_valid=1
bit_valid  input  1  qualifies bit_in for the current clk edge
cs_n  input  1  frame select, active-low; 1 = no transaction
frame_data  output  8*FRAME_BYTES  last completed frame; byte 0 (first received) in bits [7:0]
frame_valid  output  1  completed frame waiting for consumer
frame_ready  input  1  consumer accepts frame_data when frame_valid=1
byte_count  output  $clog2(FRAME_BYTES+1)  whole bytes assembled in the current frame
busy  output  1  1 in RECV or HOLD
err_abort  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; frame_data=0, frame_valid=0, byte_count=0, busy=0, err_abort=0; bit counter, assembly buffer and timeout counter cleared. Reset mid-frame or mid-HOLD discards everything, including a pending frame.
- States: IDLE, RECV, HOLD.
- IDLE: bit_valid ignored. If cs_n=0 -> RECV; bits are sampled from the next edge onward.
- RECV, bit sampling: on an edge with bit_valid=1, bit_in enters the byte assembler LSB-first. The first bit lands in bit 0, the 8th bit in bit 7.
- RECV, byte completion: on the 8th bit, the byte is written to slot byte_count of the internal assembly buffer and byte_count increments. byte_count is visible the following cycle.
- RECV, frame completion: when byte FRAME_BYTES completes, the assembly buffer is copied to frame_data, frame_valid=1, byte_count->0, and the state goes to HOLD. All of this is visible on the cycle after the edge that sampled the last bit (latency 1).
- frame_data changes only at frame completion. It keeps the previous frame through reception, aborts and HOLD, like a holding register.
- HOLD: frame_valid=1 and frame_data stable. bit_valid is ignored, so bits arriving in HOLD are dropped and the sender must respect handshake back-pressure.
- HOLD exit: on an edge with frame_ready=1, frame_valid->0. Next state is RECV if cs_n=0, else IDLE. cs_n rising in HOLD does not drop the pending frame.
- Abort (RECV only), condition (a): cs_n=1 with a partial frame (bit counter !=0 or byte_count !=0).
- Abort (RECV only), condition (b): the timeout counter reaches TIMEOUT with a partial frame.
- Abort action: clear the bit counter, byte_count and assembly buffer; pulse err_abort for exactly 1 cycle; go to IDLE. frame_data is unchanged.
- cs_n=1 in RECV with nothing received: go to IDLE silently, no err_abort.
- Timeout counter: increments each RECV cycle with bit_valid=0; clears on bit_valid=1 and outside RECV. It never fires when nothing has been received.
- Simultaneous: the 8th bit of the last byte together with cs_n=1 on the same edge -> the bit is accepted and the frame completes. Completion wins over abort and the next state is HOLD.
- Simultaneous: a timeout hit on the same edge as bit_valid=1 -> the bit wins and the counter clears.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package spi_pkg: state encoding constants (ST_IDLE, ST_RECV, ST_HOLD) and BYTE_W=8.
- One sub-module, spi_byte_deser: 8-bit LSB-first shifter with a 3-bit counter, sync clear input, byte_done pulse and byte output. The controller drives its clear on abort, reset and frame completion.
- FSM, buffer, timeout and handshake live in spi_frame_ctrl.

Test Plan:
- FRAME_BYTES=2. cs_n=0; bits 1,1,0,0,1,0,1,0 then 0,0,1,1,1,1,1,1, all bit_valid=1 -> byte_count=1 after the 8th bit; frame_valid=1 and frame_data=16'hFC53 one cycle after the 16th bit; frame_ready=1 -> frame_valid=0.
- Back-pressure: frame pending, frame_ready=0 for 10 cycles with bits toggling -> frame_data stays 16'hFC53; byte_count=0 throughout; no bits captured.
- Abort: after 5 bits, raise cs_n -> err_abort high for exactly 1 cycle; state IDLE; frame_data still 16'hFC53. A new full frame of 0xA5, 0x01 -> 16'h01A5.
- Timeout (TIMEOUT=16): 3 bits, then bit_valid=0 for 16 cycles -> err_abort pulse at the 16th idle cycle. With bit_valid=0 and no bits received, 40 cycles in RECV -> no pulse.
- Corner: the 16th bit and cs_n=1 on the same edge -> frame_valid=1, err_abort=0.
- Reset: rst_n=0 in HOLD with frame_valid=1 -> all outputs 0 the next cycle, state IDLE, then a clean frame is received.
